fft_bfly_twf_stage: RTL

//  Parametrised radix-2 DIF butterfly + twiddle-multiply stage for the pipelined FFT; processes N lane pairs per beat.

---
 rtl/fft_bfly_twf_stage.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/fft_bfly_twf_stage.sv
// Radix-2 DIF butterfly plus twiddle multiply, round and saturate, N lane pairs per beat.
// Latency 2 enabled cycles; in_ready = ~out_valid | out_ready, so the whole pipe stalls when a full output is not taken.
module fft_bfly_twf_stage #(
  parameter int N         = 8,
  parameter int IN_BIT    = 13,
  parameter int OUT_BIT   = 16,
  parameter int TW_BIT    = 9,
  parameter int TW_DEPTH  = 512,
  parameter int BLK_BEATS = 32,
  localparam int TWA      = $clog2(TW_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          start_i,
  input  logic                          bypass_i,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N-1:0][IN_BIT-1:0]      din1_i,
  input  logic [N-1:0][IN_BIT-1:0]      din1_q,
  input  logic [N-1:0][IN_BIT-1:0]      din2_i,
  input  logic [N-1:0][IN_BIT-1:0]      din2_q,
  output logic [N-1:0][TWA-1:0]         tw_idx_lo,
  output logic [N-1:0][TWA-1:0]         tw_idx_hi,
  input  logic [N-1:0][TW_BIT-1:0]      tw_lo_re,
  input  logic [N-1:0][TW_BIT-1:0]      tw_lo_im,
  input  logic [N-1:0][TW_BIT-1:0]      tw_hi_re,
  input  logic [N-1:0][TW_BIT-1:0]      tw_hi_im,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic [N-1:0][OUT_BIT-1:0]     dout1_i,
  output logic [N-1:0][OUT_BIT-1:0]     dout1_q,
  output logic [N-1:0][OUT_BIT-1:0]     dout2_i,
  output logic [N-1:0][OUT_BIT-1:0]     dout2_q
);

  localparam int CW = (BLK_BEATS > 1) ? $clog2(BLK_BEATS) : 1;
  localparam int SW = IN_BIT + 1;
  localparam int PW = IN_BIT + TW_BIT + 2;
  localparam int SH = TW_BIT - 2;
  localparam logic [CW-1:0]             LAST_IDX = CW'(BLK_BEATS - 1);
  localparam logic signed [TW_BIT-1:0]  TW_ONE   = TW_BIT'(1 << SH);
  localparam logic signed [PW-1:0]      RND      = PW'(1 << (SH - 1));
  localparam logic signed [PW-1:0]      SAT_MAX  = PW'((1 << (OUT_BIT - 1)) - 1);
  localparam logic signed [PW-1:0]      SAT_MIN  = ~SAT_MAX;

  logic                      en, accept;
  logic [CW-1:0]             idx;
  logic [TWA-1:0]            tw_base;

  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      v1_q, v1_d, last1_q, last1_d;
  logic [CW-1:0]             cnt1_q, cnt1_d;
  logic [N-1:0][SW-1:0]      sum_i_q, sum_i_d, sum_q_q, sum_q_d;
  logic [N-1:0][SW-1:0]      dif_i_q, dif_i_d, dif_q_q, dif_q_d;
  logic                      v2_q, v2_d, last2_q, last2_d;
  logic [N-1:0][OUT_BIT-1:0] dout1_i_q, dout1_i_d, dout1_q_q, dout1_q_d;
  logic [N-1:0][OUT_BIT-1:0] dout2_i_q, dout2_i_d, dout2_q_q, dout2_q_d;

  // Round half toward +inf, then clamp into the OUT_BIT signed range.
  function automatic logic [OUT_BIT-1:0] rnd_sat(input logic signed [PW-1:0] x);
    logic signed [PW-1:0] r;
    r = (x + RND) >>> SH;
    if (r > SAT_MAX)      rnd_sat = SAT_MAX[OUT_BIT-1:0];
    else if (r < SAT_MIN) rnd_sat = SAT_MIN[OUT_BIT-1:0];
    else                  rnd_sat = r[OUT_BIT-1:0];
  endfunction

  // Returns {im, re} of a*w after rounding and saturation.
  function automatic logic [2*OUT_BIT-1:0] cmul_rs(
    input logic signed [SW-1:0]     a_re,
    input logic signed [SW-1:0]     a_im,
    input logic signed [TW_BIT-1:0] w_re,
    input logic signed [TW_BIT-1:0] w_im
  );
    logic signed [PW-1:0] p_re, p_im;
    p_re = PW'(a_re) * PW'(w_re) - PW'(a_im) * PW'(w_im);
    p_im = PW'(a_re) * PW'(w_im) + PW'(a_im) * PW'(w_re);
    cmul_rs = {rnd_sat(p_im), rnd_sat(p_re)};
  endfunction

  always_comb begin
    en     = ~v2_q | out_ready;
    accept = in_valid & en;
    idx    = start_i ? '0 : cnt_q;

    cnt_d = cnt_q;
    if (accept)       cnt_d = (idx == LAST_IDX) ? '0 : idx + CW'(1);
    else if (start_i) cnt_d = '0;

    v1_d    = v1_q;
    last1_d = last1_q;
    cnt1_d  = cnt1_q;
    sum_i_d = sum_i_q;
    sum_q_d = sum_q_q;
    dif_i_d = dif_i_q;
    dif_q_d = dif_q_q;
    if (en) begin
      v1_d    = accept;
      cnt1_d  = idx;
      last1_d = (idx == LAST_IDX);
      for (int k = 0; k < N; k++) begin
        sum_i_d[k] = SW'($signed(din1_i[k])) + SW'($signed(din2_i[k]));
        sum_q_d[k] = SW'($signed(din1_q[k])) + SW'($signed(din2_q[k]));
        dif_i_d[k] = SW'($signed(din1_i[k])) - SW'($signed(din2_i[k]));
        dif_q_d[k] = SW'($signed(din1_q[k])) - SW'($signed(din2_q[k]));
      end
    end
  end

  // Twiddle addresses follow the beat held in stage 1, so the ROM answers in time for stage 2.
  always_comb begin
    tw_base = TWA'(32'(cnt1_q) * 32'(2 * N));
    for (int k = 0; k < N; k++) begin
      tw_idx_lo[k] = tw_base + TWA'(k);
      tw_idx_hi[k] = tw_base + TWA'(k + N);
    end
  end

  always_comb begin
    v2_d      = v2_q;
    last2_d   = last2_q;
    dout1_i_d = dout1_i_q;
    dout1_q_d = dout1_q_q;
    dout2_i_d = dout2_i_q;
    dout2_q_d = dout2_q_q;
    if (en) begin
      v2_d    = v1_q;
      last2_d = last1_q;
      for (int k = 0; k < N; k++) begin
        {dout1_q_d[k], dout1_i_d[k]} = cmul_rs($signed(sum_i_q[k]), $signed(sum_q_q[k]),
                                               bypass_i ? TW_ONE : tw_lo_re[k],
                                               bypass_i ? '0     : tw_lo_im[k]);
        {dout2_q_d[k], dout2_i_d[k]} = cmul_rs($signed(dif_i_q[k]), $signed(dif_q_q[k]),
                                               bypass_i ? TW_ONE : tw_hi_re[k],
                                               bypass_i ? '0     : tw_hi_im[k]);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= '0;
      v1_q      <= 1'b0;
      last1_q   <= 1'b0;
      cnt1_q    <= '0;
      sum_i_q   <= '0;
      sum_q_q   <= '0;
      dif_i_q   <= '0;
      dif_q_q   <= '0;
      v2_q      <= 1'b0;
      last2_q   <= 1'b0;
      dout1_i_q <= '0;
      dout1_q_q <= '0;
      dout2_i_q <= '0;
      dout2_q_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      v1_q      <= v1_d;
      last1_q   <= last1_d;
      cnt1_q    <= cnt1_d;
      sum_i_q   <= sum_i_d;
      sum_q_q   <= sum_q_d;
      dif_i_q   <= dif_i_d;
      dif_q_q   <= dif_q_d;
      v2_q      <= v2_d;
      last2_q   <= last2_d;
      dout1_i_q <= dout1_i_d;
      dout1_q_q <= dout1_q_d;
      dout2_i_q <= dout2_i_d;
      dout2_q_q <= dout2_q_d;
    end
  end

  assign in_ready  = en;
  assign out_valid = v2_q;
  assign out_last  = last2_q;
  assign dout1_i   = dout1_i_q;
  assign dout1_q   = dout1_q_q;
  assign dout2_i   = dout2_i_q;
  assign dout2_q   = dout2_q_q;

endmodule
